// File: rtl/sub64_issue_ctrl.sv
// Issue controller for the signed subtractor wrapper: holds operands and ce
// until the wrapper's valid pulse, captures the difference and derives flags.
//
// state | meaning
// IDLE  | ready for an operand pair; core_ce low
// RUN   | core_ce high, operands held, watchdog counting
// DONE  | result (or timeout error) presented until out_ready
module sub64_issue_ctrl #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_err,
    output logic             core_ce,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_valid,
    input  logic [WIDTH-1:0] core_s
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wd_cnt;
    logic          accept;
    logic          hit;
    logic          tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // core_valid outranks the watchdog when both land in the same cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hit       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (core_valid) begin
                    hit       = 1'b1;
                    state_nxt = DONE;
                end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_a   <= '0;
            core_b   <= '0;
            wd_cnt   <= '0;
            out_diff <= '0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                core_a <= in_a;
                core_b <= in_b;
                wd_cnt <= '0;
            end else if (state == RUN) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (hit) begin
                out_diff <= core_s;
                out_ovf  <= (core_a[WIDTH-1] != core_b[WIDTH-1]) &&
                            (core_s[WIDTH-1] != core_a[WIDTH-1]);
                out_zero <= (core_s == '0);
                out_err  <= 1'b0;
            end else if (tmo) begin
                out_diff <= '0;
                out_ovf  <= 1'b0;
                out_zero <= 1'b0;
                out_err  <= 1'b1;
            end
        end
    end

    // dropping ce outside RUN flushes the wrapper's valid pipeline
    assign core_ce   = (state == RUN);
    assign out_valid = (state == DONE);
    assign in_ready  = (state == IDLE) && !reset;

endmodule

// File: doc/sub64_issue_ctrl.md
# sub64_issue_ctrl

Issue controller that sits directly upstream of the signed 64-bit subtractor wrapper and drives it. It accepts one operand pair at a time over a valid/ready handshake, holds the operands and clock-enable stable until the wrapper's one-cycle `valid` pulse, captures the difference, and derives overflow and zero flags. It presents the result downstream over a valid/ready handshake. A timeout watchdog reports an error if the wrapper never responds.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width; must match the subtractor wrapper.
- `TIMEOUT`, 15: maximum RUN cycles before abort; must be ≥ 7.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `in_a`  in  WIDTH  minuend, signed.
- `in_b`  in  WIDTH  subtrahend, signed.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_diff`  out  WIDTH  captured A−B (0 on error).
- `out_ovf`  out  1  signed overflow of A−B.
- `out_zero`  out  1  out_diff == 0 and no error.
- `out_err`  out  1  wrapper timed out.
- `core_ce`  out  1  to wrapper `ce`.
- `core_a`  out  WIDTH  to wrapper `A`.
- `core_b`  out  WIDTH  to wrapper `B`.
- `core_valid`  in  1  from wrapper `valid`.
- `core_s`  in  WIDTH  from wrapper `S`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: register `in_a`/`in_b` into `core_a`/`core_b`, clear the watchdog counter, go to RUN.
- RUN:
  - `core_ce`=1, `core_a`/`core_b` held constant.
  - Watchdog counter increments each cycle; its width is clog2(TIMEOUT+1).
  - On `core_valid`=1:
    - register `out_diff`=`core_s`.
    - `out_ovf` = (A[W-1]≠B[W-1]) & (S[W-1]≠A[W-1]), using the registered A/B and `core_s`.
    - `out_zero` = (`core_s`==0).
    - `out_err`=0.
    - go to DONE.
  - Else if the counter equals TIMEOUT−1:
    - `out_diff`=0, `out_ovf`=0, `out_zero`=0, `out_err`=1.
    - go to DONE.
  - `core_valid` takes priority over timeout in the same cycle.
- DONE:
  - `core_ce`=0, which clears the wrapper's internal valid shift register.
  - `out_valid`=1; all `out_*` data and flags stay stable while `out_ready`=0.
  - On `out_ready`: go to IDLE.
- `core_valid` seen outside RUN is ignored.
- Arithmetic is done by the wrapper. The controller computes only the flags; it performs no width extension or truncation.
- Reset: on `reset` high at a clock edge, state=IDLE and all outputs and registers go to 0. This applies in any state, including mid-RUN; dropping `core_ce` flushes the wrapper. An operand in flight is discarded with no result.

## Timing
- Reset values:
  - `in_ready`=1 after reset release (0 while `reset` is high).
  - `out_valid`=0, `core_ce`=0; all data and flags 0.
- Handshake accepted in cycle T (IDLE, `in_valid`=1) ⇒ RUN from T+1, `core_ce`=1 from T+1.
- Wrapper `valid` arrives in cycle T+7 (6 edges with `ce` high). Controller captures at the end of T+7.
- `out_valid`=1 from T+8. With `out_ready`=1 at T+8: IDLE at T+9. Minimum initiation interval is 9 cycles.
- Timeout: RUN lasts exactly TIMEOUT cycles, so `out_valid` with `out_err`=1 appears in cycle T+1+TIMEOUT.
- `in_ready` is 0 from T+1 until the cycle after the output handshake. No input is accepted in DONE, even when `out_ready`=1 in the same cycle.
- Back-pressure has no limit; DONE holds indefinitely.

## Test plan
- A=10, B=3, `out_ready`=1 → `out_valid` at T+8; diff=7, ovf=0, zero=0, err=0; `in_ready` back at T+9.
- A=0x8000_0000_0000_0000, B=1 → diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1. Also A=0x7FFF_FFFF_FFFF_FFFF, B=−1 → diff=0x8000_0000_0000_0000, ovf=1.
- A=B=5 → diff=0, zero=1. A=−2, B=3 → diff=0xFFFF_FFFF_FFFF_FFFB, ovf=0.
- `out_ready` held 0 for 5 cycles after `out_valid` → outputs unchanged, `in_ready`=0, `core_ce`=0; the result is accepted on the 6th cycle.
- Wrapper model never pulses `valid` → `out_err`=1, diff=0 at T+16 (TIMEOUT=15); the next operation (20−8) completes normally with diff=12.
- `reset` asserted at T+4 → cycle after: state IDLE, `core_ce`=0, `out_valid`=0; no result is emitted. A new op issued after release returns correct results at T'+8.
